// File: rtl/calc_pkg.sv
// Shared state encoding for the sweep controller, its datapath and monitors.
package calc_pkg;

   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      PRE   = 4'd0,
      CHECK = 4'd1,
      OPS   = 4'd2,
      LOAD  = 4'd3,
      NEXT  = 4'd4,
      ERR   = 4'd14,
      DONE  = 4'd15
   } calc_state_e;

endpackage

// File: rtl/calc_sweep_controller_if.sv
// Handshake bundle between the sweep controller (master) and the solver datapath / program control (slave).
// The error signal exists only when STAGE_TIMEOUT_EN is defined.
interface calc_sweep_controller_if #(
   parameter int unsigned IDX_W = 3,
   parameter int unsigned SWP_W = 5
);
   logic             start_process;
   logic             end_process;
   logic             data_reset_done;
   logic             go_reset_data;
   logic [IDX_W-1:0] node_idx;
   logic             go_check_node;
   logic             node_checked;
   logic             node_valid;
   logic             go_do_ops;
   logic             ops_done;
   logic             node_changed;
   logic             ld_memory;
   logic             memory_loaded;
   logic [SWP_W-1:0] sweep_count;
   logic             converged;
   logic             busy;
   logic [3:0]       current_state;
`ifdef STAGE_TIMEOUT_EN
   logic             error;
`endif

   modport master (
      input  start_process, data_reset_done, node_checked, node_valid,
             ops_done, node_changed, memory_loaded,
`ifdef STAGE_TIMEOUT_EN
      output error,
`endif
      output end_process, go_reset_data, node_idx, go_check_node, go_do_ops,
             ld_memory, sweep_count, converged, busy, current_state
   );

   modport slave (
      output start_process, data_reset_done, node_checked, node_valid,
             ops_done, node_changed, memory_loaded,
`ifdef STAGE_TIMEOUT_EN
      input  error,
`endif
      input  end_process, go_reset_data, node_idx, go_check_node, go_do_ops,
             ld_memory, sweep_count, converged, busy, current_state
   );

endinterface

// File: rtl/calc_stage_watchdog.sv
// Per-stage watchdog: counts cycles spent in a wait state, restarting on every state entry.
// Built only when STAGE_TIMEOUT_EN is defined.
module calc_stage_watchdog
   import calc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        program_reset,
   input  calc_state_e state,
   output logic        expired_c
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   calc_state_e      prev_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] elapsed_c;
   logic             waiting_c;

   // A state change since last cycle means a fresh entry, so the stage clock restarts at zero.
   assign waiting_c = state inside {CHECK, OPS, LOAD};
   assign elapsed_c = (state != prev_state) ? '0 : cnt;
   assign expired_c = waiting_c && (elapsed_c == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge program_reset) begin
      if (program_reset) begin
         prev_state <= PRE;
         cnt        <= '0;
      end else begin
         prev_state <= state;
         if (waiting_c && !expired_c) cnt <= elapsed_c + 1'b1;
         else                         cnt <= '0;
      end
   end

endmodule

// File: rtl/calc_sweep_controller.sv
// Multi-sweep node controller: visits nodes 0..NUM_NODES-1 per sweep, repeating until a clean sweep or MAX_SWEEPS.
// Define STAGE_TIMEOUT_EN to add the per-stage watchdog, the ERR state and the error output.
module calc_sweep_controller
   import calc_pkg::*;
#(
   parameter int unsigned NUM_NODES  = 8,
   parameter int unsigned MAX_SWEEPS = 16,
   parameter int unsigned IDX_W      = $clog2(NUM_NODES),
   parameter int unsigned SWP_W      = $clog2(MAX_SWEEPS + 1)
`ifdef STAGE_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
   input logic                      clk,
   input logic                      program_reset,
   calc_sweep_controller_if.master  bus
);
   calc_state_e      state;
   logic [IDX_W-1:0] node_idx;
   logic [SWP_W-1:0] sweep_count;
   logic             dirty;
   logic             converged;

`ifdef STAGE_TIMEOUT_EN
   logic timeout_c;

   calc_stage_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .clk           (clk),
      .program_reset (program_reset),
      .state         (state),
      .expired_c     (timeout_c)
   );
`endif

   always_ff @(posedge clk or posedge program_reset) begin
      if (program_reset) begin
         state       <= PRE;
         node_idx    <= '0;
         sweep_count <= '0;
         dirty       <= 1'b0;
         converged   <= 1'b0;
      end else begin
         case (state)
            PRE: if (bus.data_reset_done && bus.start_process) begin
               node_idx    <= '0;
               sweep_count <= '0;
               dirty       <= 1'b0;
               state       <= CHECK;
            end
            CHECK: begin
               if (bus.node_checked) state <= bus.node_valid ? OPS : NEXT;
`ifdef STAGE_TIMEOUT_EN
               else if (timeout_c) begin state <= ERR; converged <= 1'b0; end
`endif
            end
            OPS: begin
               if (bus.ops_done) begin
                  state <= LOAD;
                  if (bus.node_changed) dirty <= 1'b1;
               end
`ifdef STAGE_TIMEOUT_EN
               else if (timeout_c) begin state <= ERR; converged <= 1'b0; end
`endif
            end
            LOAD: begin
               if (bus.memory_loaded) state <= NEXT;
`ifdef STAGE_TIMEOUT_EN
               else if (timeout_c) begin state <= ERR; converged <= 1'b0; end
`endif
            end
            // End of sweep decides between another pass, clean convergence, or the sweep limit.
            NEXT: begin
               if (node_idx != IDX_W'(NUM_NODES - 1)) begin
                  node_idx <= node_idx + 1'b1;
                  state    <= CHECK;
               end else begin
                  sweep_count <= sweep_count + 1'b1;
                  if (!dirty) begin
                     converged <= 1'b1;
                     state     <= DONE;
                  end else if (sweep_count == SWP_W'(MAX_SWEEPS - 1)) begin
                     converged <= 1'b0;
                     state     <= DONE;
                  end else begin
                     node_idx <= '0;
                     dirty    <= 1'b0;
                     state    <= CHECK;
                  end
               end
            end
            DONE: if (!bus.start_process) state <= PRE;
`ifdef STAGE_TIMEOUT_EN
            ERR:  if (!bus.start_process) state <= PRE;
`endif
            default: state <= PRE;
         endcase
      end
   end

   // Moore strobes decoded straight from the state register.
   assign bus.go_reset_data = (state == PRE);
   assign bus.go_check_node = (state == CHECK);
   assign bus.go_do_ops     = (state == OPS);
   assign bus.ld_memory     = (state == LOAD);
   assign bus.end_process   = (state == DONE) || (state == ERR);
   assign bus.busy          = state inside {CHECK, OPS, LOAD, NEXT};
   assign bus.current_state = state;
   assign bus.node_idx      = node_idx;
   assign bus.sweep_count   = sweep_count;
   assign bus.converged     = converged;
`ifdef STAGE_TIMEOUT_EN
   assign bus.error         = (state == ERR);
`endif

endmodule
